adc_spi_rx: RTL and testbench
=============================

ADC_SPI_RX -- requirements
Module: adc_spi_rx

Interface
REQ-001 Parameter DIV_SCLK, default 4: clk cycles per sclk half-period; legal range 1..255.
REQ-002 Parameter Q_CICLOS, default 8: quiet clk cycles with cs_n high after each conversion; legal range 1..255.
REQ-003 Port clk, input, 1, the single system clock; every register updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port iniciar, input, 1, conversion request, sampled only in IDLE.
REQ-006 Port sdata, input, 1, serial data from the ADC, MSB first.
REQ-007 Port cs_n, output, 1, ADC chip select, active low.
REQ-008 Port sclk, output, 1, ADC serial clock, idle high.
REQ-009 Port dato, output, 12, last converted sample, unsigned, held between updates.
REQ-010 Port dato_listo, output, 1, one-cycle pulse marking a dato update.
REQ-011 Port ocupado, output, 1, high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, CONV and QUIET.
REQ-013 IDLE -> CONV on the edge where iniciar=1; from the next cycle cs_n=0, sclk=0, bit counter=0, divider=0.
REQ-014 Each bit in CONV SHALL be DIV_SCLK cycles with sclk=0 followed by DIV_SCLK cycles with sclk=1.
REQ-015 sdata SHALL be sampled into the shift register on the clk edge that drives sclk from 0 to 1.
REQ-016 Exactly 16 bits per frame: bits 15:12 are leading zeros and are discarded; bits 11:0 form the sample.
REQ-017 CONV SHALL last exactly 32*DIV_SCLK cycles and then move to QUIET, with cs_n=1 and sclk=1 in the first QUIET cycle.
REQ-018 dato SHALL be updated and dato_listo pulsed high in the first QUIET cycle: latency from the iniciar accept edge to dato_listo is 32*DIV_SCLK+1 cycles (129 at default).
REQ-019 QUIET SHALL last Q_CICLOS cycles, then return to IDLE.
REQ-020 iniciar asserted in CONV or QUIET SHALL be ignored and not queued.
REQ-021 iniciar held high continuously SHALL start a new frame on the first IDLE cycle (back-to-back mode).
REQ-022 sclk SHALL never toggle while cs_n=1.

Reset
REQ-023 reset SHALL act on the clock edge and override all other inputs: next cycle state=IDLE, cs_n=1, sclk=1, dato=0, dato_listo=0, ocupado=0, all counters, shift register and accumulator at 0.
REQ-024 reset asserted mid-CONV SHALL abort the frame with no dato_listo pulse; the partial frame is discarded.

Configuration
REQ-025 Macro ADC_PROMEDIO_EN defined: a 14-bit accumulator sums 4 consecutive samples; dato_listo pulses only on every 4th frame, with dato = sum>>2 (truncated); accumulator and frame counter clear after each output.
REQ-026 Macro ADC_PROMEDIO_EN undefined: every frame updates dato directly, and no accumulator logic is present.

Structure
REQ-027 Shared package adc_pkg SHALL hold the state enum, the frame length constant (16), the data width constant (12) and the averaging depth constant (4).
REQ-028 Sub-module divisor_sclk SHALL generate sclk and the one-cycle sample strobe from DIV_SCLK under FSM enable; all other logic stays in adc_spi_rx.

Verification
REQ-029 ADC model sends 0x0ABC at default parameters, iniciar pulsed once -> dato=0xABC and dato_listo high exactly 129 cycles after the accept edge, 16 sclk rising edges seen while cs_n=0.
REQ-030 ADC model sends 0x0FFF, then 0x0000, with iniciar held high -> dato=0xFFF then 0x000, and cs_n high for exactly 8 cycles between frames.
REQ-031 iniciar pulsed at cycle 50 of CONV and again in QUIET -> exactly one frame and one dato_listo pulse.
REQ-032 reset asserted at sclk rising edge 9 -> next cycle cs_n=1, sclk=1, dato=0, ocupado=0, no dato_listo pulse; a fresh iniciar then completes normally.
REQ-033 With ADC_PROMEDIO_EN, samples 0x100, 0x200, 0x300, 0x401 -> a single dato_listo pulse after frame 4 with dato=0x280.
REQ-034 DIV_SCLK=1, Q_CICLOS=1 -> sclk=clk/2, latency 33 cycles, correct 0x5A5 capture.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and constants for the serial ADC receiver.
// The averaging build (ADC_PROMEDIO_EN) uses the accumulator constants below.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    QUIET = 2'd2
  } estado_t;

  localparam int LARGO_TRAMA = 16;
  localparam int ANCHO_DATO  = 12;
  localparam int PROF_PROM   = 4;
  localparam int LOG_PROM    = $clog2(PROF_PROM);
  localparam int ANCHO_ACC   = ANCHO_DATO + LOG_PROM;

endpackage

// File: rtl/adc_spi_rx_divisor_sclk.sv
// Serial clock generator: DIV_SCLK clk cycles per sclk half-period, idle high.
// Emits a sample strobe on the 0->1 edge and an end-of-bit strobe on the 1->0 edge.
module divisor_sclk #(
  parameter int DIV_SCLK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arranque,
  input  logic en,
  input  logic ultimo,
  output logic sclk,
  output logic muestra,
  output logic fin_bit
);

  localparam logic [7:0] DIV_MAX = 8'(DIV_SCLK - 1);

  logic [7:0] div;
  logic       fin_medio;

  assign fin_medio = (div == DIV_MAX);
  assign muestra   = en && !sclk && fin_medio;
  assign fin_bit   = en && sclk && fin_medio;

  // The last bit keeps sclk high so the frame ends without an extra falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk <= 1'b1;
      div  <= 8'd0;
    end else if (arranque) begin
      sclk <= 1'b0;
      div  <= 8'd0;
    end else if (en) begin
      if (fin_medio) begin
        div <= 8'd0;
        if (!(sclk && ultimo)) sclk <= ~sclk;
      end else begin
        div <= div + 8'd1;
      end
    end else begin
      sclk <= 1'b1;
      div  <= 8'd0;
    end
  end

endmodule

// File: rtl/adc_spi_rx.sv
// 16-bit frame SPI receiver for a 12-bit ADC (4 leading zeros discarded).
// Optional 4-sample averaging is enabled with the macro ADC_PROMEDIO_EN.
module adc_spi_rx
  import adc_pkg::*;
#(
  parameter int DIV_SCLK = 4,
  parameter int Q_CICLOS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iniciar,
  input  logic                  sdata,
  output logic                  cs_n,
  output logic                  sclk,
  output logic [ANCHO_DATO-1:0] dato,
  output logic                  dato_listo,
  output logic                  ocupado
);

  // The IDLE turnaround cycle counts as quiet time, so cs_n stays high for
  // Q_CICLOS cycles between back-to-back frames (QUIET needs at least one cycle).
  localparam logic [7:0] Q_ULTIMO = (Q_CICLOS > 1) ? 8'(Q_CICLOS - 2) : 8'd0;

  estado_t               estado, estado_sig;
  logic [3:0]            cnt_bit;
  logic [7:0]            cnt_q;
  logic [ANCHO_DATO-1:0] desplaz;
  logic                  arranque, en_conv, muestra, fin_bit, fin_trama, fin_quiet;

  assign arranque  = (estado == IDLE) && iniciar;
  assign en_conv   = (estado == CONV);
  assign fin_trama = en_conv && fin_bit && (cnt_bit == 4'(LARGO_TRAMA - 1));
  assign fin_quiet = (cnt_q == Q_ULTIMO);
  assign ocupado   = (estado != IDLE);

  divisor_sclk #(.DIV_SCLK(DIV_SCLK)) u_divisor (
    .clk      (clk),
    .reset    (reset),
    .arranque (arranque),
    .en       (en_conv),
    .ultimo   (cnt_bit == 4'(LARGO_TRAMA - 1)),
    .sclk     (sclk),
    .muestra  (muestra),
    .fin_bit  (fin_bit)
  );

  always_comb begin
    estado_sig = estado;
    unique case (estado)
      IDLE:    if (iniciar)   estado_sig = CONV;
      CONV:    if (fin_trama) estado_sig = QUIET;
      QUIET:   if (fin_quiet) estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

`ifdef ADC_PROMEDIO_EN
  logic [ANCHO_ACC-1:0] acc;
  logic [ANCHO_ACC-1:0] suma;
  logic [LOG_PROM-1:0]  cnt_prom;

  assign suma = acc + ANCHO_ACC'(desplaz);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      estado     <= IDLE;
      cs_n       <= 1'b1;
      cnt_bit    <= 4'd0;
      cnt_q      <= 8'd0;
      desplaz    <= '0;
      dato       <= '0;
      dato_listo <= 1'b0;
`ifdef ADC_PROMEDIO_EN
      acc        <= '0;
      cnt_prom   <= '0;
`endif
    end else begin
      estado     <= estado_sig;
      cs_n       <= (estado_sig != CONV);
      dato_listo <= 1'b0;
      cnt_q      <= (estado == QUIET) ? cnt_q + 8'd1 : 8'd0;
      if (arranque)                cnt_bit <= 4'd0;
      else if (en_conv && fin_bit) cnt_bit <= cnt_bit + 4'd1;
      // The 12-bit register naturally drops the four leading zero bits.
      if (muestra) desplaz <= {desplaz[ANCHO_DATO-2:0], sdata};
      if (fin_trama) begin
`ifdef ADC_PROMEDIO_EN
        if (cnt_prom == LOG_PROM'(PROF_PROM - 1)) begin
          dato       <= suma[ANCHO_ACC-1:LOG_PROM];
          dato_listo <= 1'b1;
          acc        <= '0;
          cnt_prom   <= '0;
        end else begin
          acc      <= suma;
          cnt_prom <= cnt_prom + 1'b1;
        end
`else
        dato       <= desplaz;
        dato_listo <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_rx.sv
// Scoreboard bench for adc_spi_rx: default instance (DIV_SCLK=4, Q_CICLOS=8)
// plus a fast instance (DIV_SCLK=1, Q_CICLOS=1), each driven by an ADC model.
module tb_adc_spi_rx;

  logic        clk = 1'b0;
  logic        reset, iniciar, sdata, cs_n, sclk, dato_listo, ocupado;
  logic [11:0] dato;
  logic        iniciar_b, sdata_b, cs_n_b, sclk_b, dato_listo_b, ocupado_b;
  logic [11:0] dato_b;

  always #5 clk = ~clk;

  adc_spi_rx #(.DIV_SCLK(4), .Q_CICLOS(8)) dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .sdata(sdata), .cs_n(cs_n),
    .sclk(sclk), .dato(dato), .dato_listo(dato_listo), .ocupado(ocupado)
  );

  adc_spi_rx #(.DIV_SCLK(1), .Q_CICLOS(1)) dut_b (
    .clk(clk), .reset(reset), .iniciar(iniciar_b), .sdata(sdata_b), .cs_n(cs_n_b),
    .sclk(sclk_b), .dato(dato_b), .dato_listo(dato_listo_b), .ocupado(ocupado_b)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] esp);
    n_chk++;
    if (act !== esp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nombre, act, esp);
    end
  endtask

  // ADC models: present frame bit (15 - rising edges seen) while cs_n is low.
  logic [15:0] trama = 16'h0, trama_b = 16'h0;
  int   sub_a = 0, fin_sub_a = 0, lo_a = 0, fin_lo_a = 0, hi_a = 0, gap_a = 0, viol_a = 0;
  int   sub_b = 0, fin_lo_b = 0, lo_b = 0, viol_b = 0;
  logic cs_prev_a = 1'b1, sclk_prev_a = 1'b1, cs_prev_b = 1'b1, sclk_prev_b = 1'b1;

  assign sdata   = (!cs_n && sub_a < 16) ? trama[4'(15 - sub_a)] : 1'b0;
  assign sdata_b = (!cs_n_b && sub_b < 16) ? trama_b[4'(15 - sub_b)] : 1'b0;

  always @(negedge clk) begin
    cs_prev_a   <= cs_n;
    sclk_prev_a <= sclk;
    if (cs_n === 1'b1 && sclk === 1'b0) viol_a <= viol_a + 1;
    if (cs_n !== 1'b0) begin
      hi_a  <= hi_a + 1;
      sub_a <= 0;
      lo_a  <= 0;
      if (!cs_prev_a) begin
        fin_sub_a <= sub_a;
        fin_lo_a  <= lo_a;
      end
    end else begin
      lo_a <= lo_a + 1;
      hi_a <= 0;
      if (cs_prev_a) gap_a <= hi_a;
      if (sclk && !sclk_prev_a) sub_a <= sub_a + 1;
    end
  end

  always @(negedge clk) begin
    cs_prev_b   <= cs_n_b;
    sclk_prev_b <= sclk_b;
    if (cs_n_b === 1'b1 && sclk_b === 1'b0) viol_b <= viol_b + 1;
    if (cs_n_b !== 1'b0) begin
      sub_b <= 0;
      lo_b  <= 0;
      if (!cs_prev_b) fin_lo_b <= lo_b;
    end else begin
      lo_b <= lo_b + 1;
      if (sclk_b && !sclk_prev_b) sub_b <= sub_b + 1;
    end
  end

  // Scoreboard: expected sample and the cycle count at which dato_listo is seen.
  typedef struct {
    logic [11:0] dato;
    int          ciclo;
  } esp_t;

  esp_t sb[$];
  esp_t sb_b[$];

  always @(negedge clk) begin
    if (dato_listo === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_dato_listo: got pulse with dato=%h at cycle %0d, expected none", dato, cyc);
      end else begin
        esp_t e;
        e = sb.pop_front();
        chk("dato", 32'(dato), 32'(e.dato));
        chk("latency_cycle", 32'(cyc), 32'(e.ciclo));
      end
    end
  end

  always @(negedge clk) begin
    if (dato_listo_b === 1'b1) begin
      if (sb_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_dato_listo_b: got pulse with dato=%h at cycle %0d, expected none", dato_b, cyc);
      end else begin
        esp_t e;
        e = sb_b.pop_front();
        chk("dato_b", 32'(dato_b), 32'(e.dato));
        chk("latency_cycle_b", 32'(cyc), 32'(e.ciclo));
      end
    end
  end

  // Issue one frame from IDLE. The accept edge is the next posedge (cyc+1);
  // dato_listo appears in the (32*DIV+1)th cycle from it, i.e. seen at cyc+1+32*DIV.
  task automatic pulso(input logic [15:0] w, input logic [11:0] e, input bit empujar);
    trama   = w;
    iniciar = 1'b1;
    if (empujar) sb.push_back('{e, cyc + 1 + 128});
    @(negedge clk);
    iniciar = 1'b0;
  endtask

  task automatic esperar_libre(input int max);
    int n;
    n = 0;
    while (ocupado !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(ocupado), 32'd0);
  endtask

  task automatic esperar_cs(input logic v, input int max, input string nombre);
    int n;
    n = 0;
    while (cs_n !== v && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(nombre, 32'(cs_n), 32'(v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b1;
    iniciar   = 1'b0;
    iniciar_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_dato", 32'(dato), 32'd0);
    chk("rst_dato_listo", 32'(dato_listo), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    reset = 1'b0;
    @(negedge clk);

`ifdef ADC_PROMEDIO_EN
    // 0x100+0x200+0x300+0x401 = 0xA01, >>2 = 0x280; only the 4th frame reports.
    pulso(16'h0100, 12'h000, 1'b0); esperar_libre(300);
    pulso(16'h0200, 12'h000, 1'b0); esperar_libre(300);
    pulso(16'h0300, 12'h000, 1'b0); esperar_libre(300);
    pulso(16'h0401, 12'h280, 1'b1); esperar_libre(300);
    chk("avg_dato_hold", 32'(dato), 32'h280);
`else
    // Single frame 0x0ABC.
    pulso(16'h0ABC, 12'hABC, 1'b1);
    esperar_libre(300);
    chk("sclk_rises", 32'(fin_sub_a), 32'd16);
    chk("cs_low_cycles", 32'(fin_lo_a), 32'd128);
    repeat (5) @(negedge clk);
    chk("dato_hold", 32'(dato), 32'hABC);

    // Back-to-back with iniciar held: 0x0FFF then 0x0000, second accept 136 cycles later.
    trama   = 16'h0FFF;
    iniciar = 1'b1;
    sb.push_back('{12'hFFF, cyc + 1 + 128});
    sb.push_back('{12'h000, cyc + 1 + 136 + 128});
    esperar_cs(1'b0, 5, "b2b_start1");
    esperar_cs(1'b1, 200, "b2b_end1");
    trama = 16'h0000;
    esperar_cs(1'b0, 50, "b2b_start2");
    @(negedge clk);
    chk("b2b_cs_gap", 32'(gap_a), 32'd8);
    iniciar = 1'b0;
    esperar_libre(300);

    // iniciar in CONV (cycle 50) and in QUIET is ignored.
    pulso(16'h0321, 12'h321, 1'b1);
    repeat (49) @(negedge clk);
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    esperar_cs(1'b1, 200, "ign_quiet");
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    esperar_libre(300);
    repeat (20) @(negedge clk);
    chk("ign_no_restart", 32'(ocupado), 32'd0);

    // Reset after the 9th sclk rising edge aborts the frame.
    pulso(16'h0777, 12'h777, 1'b0);
    n = 0;
    while (sub_a < 9 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_edge9", 32'(sub_a >= 9), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", 32'(cs_n), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd1);
    chk("abort_dato", 32'(dato), 32'd0);
    chk("abort_ocupado", 32'(ocupado), 32'd0);
    chk("abort_dato_listo", 32'(dato_listo), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    pulso(16'h0BEE, 12'hBEE, 1'b1);
    esperar_libre(300);

    // Fast instance: sclk = clk/2, 33-cycle latency.
    trama_b   = 16'h05A5;
    iniciar_b = 1'b1;
    sb_b.push_back('{12'h5A5, cyc + 1 + 32});
    @(negedge clk);
    iniciar_b = 1'b0;
    n = 0;
    while (ocupado_b !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fast_idle", 32'(ocupado_b), 32'd0);
    chk("fast_cs_low_cycles", 32'(fin_lo_b), 32'd32);
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("sb_b_empty", 32'(sb_b.size()), 32'd0);
    chk("sclk_idle_high", 32'(viol_a + viol_b), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
